// File: rtl/tick_timer_scheduler_if.sv
// Arm-request and expiry-event handshake bundle of the tick timer scheduler.
// The requester/consumer side takes master; the scheduler takes slave.
interface tick_timer_scheduler_if #(
  parameter int CH_W   = 2,
  parameter int TICK_W = 16
);
  logic              arm_valid;
  logic              arm_ready;
  logic [CH_W-1:0]   arm_chan;
  logic [TICK_W-1:0] arm_ticks;
  logic              arm_periodic;
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_chan;
  logic              evt_overrun;

  modport master (
    output arm_valid, arm_chan, arm_ticks, arm_periodic, evt_ready,
    input  arm_ready, evt_valid, evt_chan, evt_overrun
  );

  modport slave (
    input  arm_valid, arm_chan, arm_ticks, arm_periodic, evt_ready,
    output arm_ready, evt_valid, evt_chan, evt_overrun
  );
endinterface

// File: rtl/tick_timer_scheduler.sv
// Multi-channel tick timer: a DIVIDE-cycle prescaler drives NCH one-shot/periodic
// channels whose expiries are presented round-robin on a valid/ready event port.
module tick_timer_scheduler #(
  parameter int DIVIDE = 1000,
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int TICK_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en_i,
  output logic             tick_out_o,
  output logic [NCH-1:0]   busy_o,
  tick_timer_scheduler_if.slave bus
);
  localparam int CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  typedef enum logic {ARM_IDLE = 1'b0, ARM_ACK = 1'b1} arm_state_e;
  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_e;

  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick_q, tick_d;
  arm_state_e        arm_state_q, arm_state_d;
  ch_state_e         ch_state_q [NCH];
  ch_state_e         ch_state_d [NCH];
  logic [TICK_W-1:0] rem_q [NCH];
  logic [TICK_W-1:0] rem_d [NCH];
  logic [TICK_W-1:0] period_q [NCH];
  logic [TICK_W-1:0] period_d [NCH];
  logic [NCH-1:0]    periodic_q, periodic_d, pending_q, pending_d, overrun_q, overrun_d;
  logic [NCH-1:0]    expire, cancel, hs;
  logic              evt_valid_q, evt_valid_d, evt_overrun_q, evt_overrun_d;
  logic [CH_W-1:0]   evt_chan_q, evt_chan_d, rr_start_q, rr_start_d;
  logic              arm_fire, evt_fire, found;
  int                idx;

  function automatic logic [CH_W-1:0] next_chan(input logic [CH_W-1:0] c);
    if (int'(c) >= NCH - 1) begin
      return '0;
    end else begin
      return c + CH_W'(1);
    end
  endfunction

  assign arm_fire      = bus.arm_valid && (arm_state_q == ARM_IDLE);
  assign evt_fire      = evt_valid_q && bus.evt_ready;
  assign bus.arm_ready = (arm_state_q == ARM_IDLE);
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_chan    = evt_chan_q;
  assign bus.evt_overrun = evt_overrun_q;
  assign tick_out_o    = tick_q;

  // Prescaler: wrap at DIVIDE-1 and flag the tick for the next cycle.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    if (tick_en_i) begin
      if (pre_cnt_q == CNT_W'(DIVIDE - 1)) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + CNT_W'(1);
      end
    end else begin
      pre_cnt_d = pre_cnt_q;
    end
  end

  // Arm port: one ACK cycle with ready low after every accept.
  always_comb begin
    arm_state_d = arm_state_q;
    case (arm_state_q)
      ARM_IDLE: arm_state_d = arm_fire ? ARM_ACK : ARM_IDLE;
      ARM_ACK:  arm_state_d = ARM_IDLE;
      default:  arm_state_d = ARM_IDLE;
    endcase
  end

  // Channel FSMs; an arm to a channel overrides a coincident tick for it.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_state_d[i] = ch_state_q[i];
      rem_d[i]      = rem_q[i];
      period_d[i]   = period_q[i];
      periodic_d[i] = periodic_q[i];
      expire[i]     = 1'b0;
      cancel[i]     = 1'b0;
      busy_o[i]     = (ch_state_q[i] == CH_RUN);
      if (arm_fire && (int'(bus.arm_chan) == i)) begin
        if (bus.arm_ticks == '0) begin
          ch_state_d[i] = CH_IDLE;
          cancel[i]     = 1'b1;
        end else begin
          ch_state_d[i] = CH_RUN;
          rem_d[i]      = bus.arm_ticks;
          period_d[i]   = bus.arm_ticks;
          periodic_d[i] = bus.arm_periodic;
        end
      end else if (tick_q && (ch_state_q[i] == CH_RUN)) begin
        if (rem_q[i] <= TICK_W'(1)) begin
          expire[i] = 1'b1;
          if (periodic_q[i]) begin
            rem_d[i] = period_q[i];
          end else begin
            ch_state_d[i] = CH_IDLE;
          end
        end else begin
          rem_d[i] = rem_q[i] - TICK_W'(1);
        end
      end else begin
        ch_state_d[i] = ch_state_q[i];
      end
    end
  end

  // Pending/overrun flags; an acceptance coinciding with a new expiry leaves a fresh event.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hs[i]        = evt_fire && (int'(evt_chan_q) == i);
      pending_d[i] = pending_q[i];
      overrun_d[i] = overrun_q[i];
      if (cancel[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end else if (expire[i]) begin
        pending_d[i] = 1'b1;
        overrun_d[i] = hs[i] ? 1'b0 : (pending_q[i] | overrun_q[i]);
      end else if (hs[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Event presentation: hold the current event, else pick round-robin from rr_start.
  always_comb begin
    evt_valid_d   = 1'b0;
    evt_chan_d    = evt_chan_q;
    evt_overrun_d = 1'b0;
    found         = 1'b0;
    idx           = 0;
    if (evt_fire) begin
      rr_start_d = next_chan(evt_chan_q);
    end else begin
      rr_start_d = rr_start_q;
    end
    if (evt_valid_q && !evt_fire && pending_d[evt_chan_q]) begin
      evt_valid_d   = 1'b1;
      evt_overrun_d = overrun_d[evt_chan_q];
    end else begin
      for (int k = 0; k < NCH; k++) begin
        idx = (int'(rr_start_d) + k) % NCH;
        if (!found && pending_d[idx]) begin
          found         = 1'b1;
          evt_valid_d   = 1'b1;
          evt_chan_d    = CH_W'(idx);
          evt_overrun_d = overrun_d[idx];
        end else begin
          found = found;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      tick_q        <= 1'b0;
      arm_state_q   <= ARM_IDLE;
      periodic_q    <= '0;
      pending_q     <= '0;
      overrun_q     <= '0;
      evt_valid_q   <= 1'b0;
      evt_chan_q    <= '0;
      evt_overrun_q <= 1'b0;
      rr_start_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        ch_state_q[i] <= CH_IDLE;
        rem_q[i]      <= '0;
        period_q[i]   <= '0;
      end
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      tick_q        <= tick_d;
      arm_state_q   <= arm_state_d;
      periodic_q    <= periodic_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      evt_valid_q   <= evt_valid_d;
      evt_chan_q    <= evt_chan_d;
      evt_overrun_q <= evt_overrun_d;
      rr_start_q    <= rr_start_d;
      for (int i = 0; i < NCH; i++) begin
        ch_state_q[i] <= ch_state_d[i];
        rem_q[i]      <= rem_d[i];
        period_q[i]   <= period_d[i];
      end
    end
  end
endmodule
